// File: rtl/dcache_evict_ctrl.sv
// dcache_evict_ctrl: TTL-aged victim selection plus write-back and burst refill sequencer for the data cache.
// Ports:
//   i_clk, i_reset            clock and asynchronous active-high reset
//   i_req_valid, i_line_miss  core access strobe and per-line miss flags (drive TTL aging)
//   i_line_dirty              per-line dirty flags
//   i_line_memory_section     line-aligned base address of each line, line i at [i*ADDRBITS +: ADDRBITS]
//   i_miss_valid, i_miss_addr refill request (held until o_miss_ack) and missing byte address
//   o_miss_ack, o_busy        refill-complete pulse and not-idle flag
//   o_flush_mode              one-hot victim select while flushing/filling
//   o_flush_rd, i_flush_data  line word read strobe and its data (one cycle later)
//   o_flush_we, o_flush_addr, o_flush_in  line word write port
//   o_mem_addr, o_mem_in, o_mem_wrreq, i_mem_wr_ack        memory word write handshake
//   o_mem_rdreq, i_mem_out, i_mem_out_valid, i_mem_burstlen  memory burst read
module dcache_evict_ctrl #(
    parameter int DATABITS      = 32,
    parameter int ADDRBITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int LINENUM       = 4,
    parameter int TTLBITS       = 8,
    parameter int MAXTTL        = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_req_valid,
    input  logic [LINENUM-1:0]          i_line_miss,
    input  logic [LINENUM-1:0]          i_line_dirty,
    input  logic [LINENUM*ADDRBITS-1:0] i_line_memory_section,
    input  logic                        i_miss_valid,
    input  logic [ADDRBITS-1:0]         i_miss_addr,
    output logic                        o_miss_ack,
    output logic                        o_busy,
    output logic [LINENUM-1:0]          o_flush_mode,
    output logic                        o_flush_rd,
    input  logic [DATABITS-1:0]         i_flush_data,
    output logic                        o_flush_we,
    output logic [ADDRBITS-1:0]         o_flush_addr,
    output logic [DATABITS-1:0]         o_flush_in,
    output logic [ADDRBITS-1:0]         o_mem_addr,
    output logic [DATABITS-1:0]         o_mem_in,
    output logic                        o_mem_wrreq,
    input  logic                        i_mem_wr_ack,
    output logic                        o_mem_rdreq,
    input  logic [DATABITS-1:0]         i_mem_out,
    input  logic                        i_mem_out_valid,
    input  logic [15:0]                 i_mem_burstlen
);
    localparam int WORDS = 1 << CACHEADDRBITS;
    localparam int CW = CACHEADDRBITS + 1;
    localparam int IW = (LINENUM > 1) ? $clog2(LINENUM) : 1;
    localparam logic [ADDRBITS-1:0] LINE_MASK = ADDRBITS'(WORDS * 4 - 1);
    localparam logic [TTLBITS-1:0] TTL_MAX = TTLBITS'(MAXTTL);

    typedef enum logic [2:0] {IDLE, SELECT, FLUSH_RD, FLUSH_WR, FILL_REQ, FILL_DATA, DONE} state_t;

    state_t                r_state;
    logic [TTLBITS-1:0]    r_ttl [LINENUM];
    logic [CW-1:0]         r_cnt;
    logic [15:0]           r_bcnt;
    logic [15:0]           r_beats;
    logic [ADDRBITS-1:0]   r_sect;
    logic                  r_wr_first;
    logic [LINENUM-1:0]    r_flush_mode;
    logic                  r_flush_rd;
    logic [ADDRBITS-1:0]   r_mem_addr;
    logic [DATABITS-1:0]   r_mem_in;
    logic                  r_mem_wrreq;
    logic                  r_mem_rdreq;
    logic                  r_miss_ack;

    logic [IW-1:0]         w_vic;
    logic [TTLBITS-1:0]    w_max;
    logic [ADDRBITS-1:0]   w_sect;
    logic                  w_vdirty;
    logic                  w_age;
    logic [ADDRBITS-1:0]   w_base;
    logic [ADDRBITS-1:0]   w_off;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_room;
    logic [CW-1:0]         w_cnt_fill;
    logic [15:0]           w_bcnt_inc;

    // Strict '>' scan keeps the lowest index on TTL ties.
    always_comb begin
        w_vic    = '0;
        w_max    = r_ttl[0];
        w_sect   = i_line_memory_section[0 +: ADDRBITS];
        w_vdirty = i_line_dirty[0];
        for (int i = 1; i < LINENUM; i++) begin
            if (r_ttl[i] > w_max) begin
                w_vic    = IW'(i);
                w_max    = r_ttl[i];
                w_sect   = i_line_memory_section[i*ADDRBITS +: ADDRBITS];
                w_vdirty = i_line_dirty[i];
            end
        end
    end

    assign w_age      = i_req_valid && !(&i_line_miss);
    assign w_base     = i_miss_addr & ~LINE_MASK;
    assign w_off      = ADDRBITS'({r_cnt, 2'b00});
    assign w_cnt_inc  = r_cnt + CW'(1);
    // r_cnt never exceeds WORDS, so its top bit alone marks a full line.
    assign w_room     = ~r_cnt[CW-1];
    assign w_cnt_fill = r_cnt + CW'(w_room);
    assign w_bcnt_inc = r_bcnt + 16'd1;

    // The line write port is driven straight from the beat so each word lands while flush_mode is still valid.
    assign o_busy       = r_state != IDLE;
    assign o_flush_we   = (r_state == FILL_DATA) && i_mem_out_valid && w_room;
    assign o_flush_in   = o_flush_we ? i_mem_out : '0;
    assign o_flush_addr = (r_state == FLUSH_RD || r_state == FLUSH_WR) ? r_sect + w_off :
                          o_flush_we ? w_base + w_off : '0;
    assign o_flush_mode = r_flush_mode;
    assign o_flush_rd   = r_flush_rd;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_in     = r_mem_in;
    assign o_mem_wrreq  = r_mem_wrreq;
    assign o_mem_rdreq  = r_mem_rdreq;
    assign o_miss_ack   = r_miss_ack;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bcnt       <= '0;
            r_beats      <= '0;
            r_sect       <= '0;
            r_wr_first   <= 1'b0;
            r_flush_mode <= '0;
            r_flush_rd   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
            r_mem_wrreq  <= 1'b0;
            r_mem_rdreq  <= 1'b0;
            r_miss_ack   <= 1'b0;
            for (int i = 0; i < LINENUM; i++) r_ttl[i] <= '0;
        end else begin
            if (r_state == IDLE && w_age) begin
                for (int i = 0; i < LINENUM; i++)
                    r_ttl[i] <= i_line_miss[i] ? ((r_ttl[i] == TTL_MAX) ? r_ttl[i] : r_ttl[i] + TTLBITS'(1))
                                               : ((r_ttl[i] == '0) ? r_ttl[i] : r_ttl[i] - TTLBITS'(1));
            end
            case (r_state)
                IDLE: begin
                    if (i_miss_valid) r_state <= SELECT;
                end
                SELECT: begin
                    r_ttl[w_vic] <= '0;
                    r_flush_mode <= LINENUM'(1) << w_vic;
                    r_cnt        <= '0;
                    r_sect       <= w_sect;
                    if (w_vdirty) begin
                        r_state    <= FLUSH_RD;
                        r_flush_rd <= 1'b1;
                    end else begin
                        r_state     <= FILL_REQ;
                        r_mem_rdreq <= 1'b1;
                        r_mem_addr  <= w_base;
                    end
                end
                FLUSH_RD: begin
                    r_flush_rd <= 1'b0;
                    r_wr_first <= 1'b1;
                    r_state    <= FLUSH_WR;
                end
                FLUSH_WR: begin
                    // First cycle only captures the word returned by the preceding line read.
                    if (r_wr_first) begin
                        r_wr_first  <= 1'b0;
                        r_mem_in    <= i_flush_data;
                        r_mem_addr  <= r_sect + w_off;
                        r_mem_wrreq <= 1'b1;
                    end else if (i_mem_wr_ack) begin
                        r_mem_wrreq <= 1'b0;
                        if (w_cnt_inc == CW'(WORDS)) begin
                            r_cnt       <= '0;
                            r_state     <= FILL_REQ;
                            r_mem_rdreq <= 1'b1;
                            r_mem_addr  <= w_base;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_state    <= FLUSH_RD;
                            r_flush_rd <= 1'b1;
                        end
                    end
                end
                FILL_REQ: begin
                    r_mem_rdreq <= 1'b0;
                    r_beats     <= (i_mem_burstlen == 16'd0) ? 16'd1 : i_mem_burstlen;
                    r_bcnt      <= '0;
                    r_state     <= FILL_DATA;
                end
                FILL_DATA: begin
                    if (i_mem_out_valid) begin
                        r_cnt  <= w_cnt_fill;
                        r_bcnt <= w_bcnt_inc;
                        if (w_bcnt_inc == r_beats) begin
                            if (w_cnt_fill == CW'(WORDS)) begin
                                r_state      <= DONE;
                                r_miss_ack   <= 1'b1;
                                r_flush_mode <= '0;
                            end else begin
                                r_state     <= FILL_REQ;
                                r_mem_rdreq <= 1'b1;
                                r_mem_addr  <= w_base + ADDRBITS'({w_cnt_fill, 2'b00});
                            end
                        end
                    end
                end
                DONE: begin
                    r_miss_ack <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_evict_ctrl.sv
// tb_dcache_evict_ctrl: directed bench for dcache_evict_ctrl with line-array and memory responders.
module tb_dcache_evict_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [3:0]   line_miss = '0;
    logic [3:0]   line_dirty = 4'b0100;
    logic [127:0] sect = {32'h4000, 32'h1000, 32'h2000, 32'h3000};
    logic         miss_valid = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic [31:0]  flush_data = '0;
    logic [31:0]  mem_out = '0;
    logic         mem_wr_ack = 1'b0;
    logic         mem_out_valid = 1'b0;
    logic [15:0]  burstlen = 16'd8;
    logic         miss_ack, busy, flush_rd, flush_we, mem_wrreq, mem_rdreq;
    logic [3:0]   flush_mode;
    logic [31:0]  flush_addr, flush_in, mem_addr, mem_in;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    dcache_evict_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_line_miss(line_miss),
        .i_line_dirty(line_dirty), .i_line_memory_section(sect), .i_miss_valid(miss_valid),
        .i_miss_addr(miss_addr), .o_miss_ack(miss_ack), .o_busy(busy), .o_flush_mode(flush_mode),
        .o_flush_rd(flush_rd), .i_flush_data(flush_data), .o_flush_we(flush_we),
        .o_flush_addr(flush_addr), .o_flush_in(flush_in), .o_mem_addr(mem_addr), .o_mem_in(mem_in),
        .o_mem_wrreq(mem_wrreq), .i_mem_wr_ack(mem_wr_ack), .o_mem_rdreq(mem_rdreq),
        .i_mem_out(mem_out), .i_mem_out_valid(mem_out_valid), .i_mem_burstlen(burstlen)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] gdat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobes"}, {120'd0, miss_ack, busy, flush_rd, flush_we, mem_wrreq, mem_rdreq}, '0);
        chk({tag, "_mode"}, {124'd0, flush_mode}, '0);
        chk({tag, "_buses"}, {flush_addr, flush_in, mem_addr, mem_in}, '0);
    endtask

    task automatic age(input int n, input logic [3:0] pattern);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            line_miss = pattern;
        end
        @(negedge clk);
        req_valid = 1'b0;
        line_miss = '0;
    endtask

    task automatic run_miss(input string nm, input logic [31:0] maddr, input logic [15:0] bl,
                            input int ack_dly, input bit aging, input int rst_after,
                            input logic [3:0] exp_mode, input bit exp_dirty, input logic [31:0] exp_sect);
        logic [31:0] base = maddr & ~32'h7F;
        logic [31:0] baddr = '0, prev_addr = '0, wa = '0, wd = '0;
        logic [3:0]  mode_seen = '0, mode_at_ack = 4'hF;
        bit          prev_rd = 0, done = 0, busy_at_ack = 0;
        int          b = (bl == 0) ? 1 : int'(bl);
        int          cyc = 0, nwr = 0, nfill = 0, nrd = 0, pend = 0, held = 0;
        int          beats_total = 0, last_beat = -10, ack_cyc = -1;
        burstlen   = bl;
        miss_addr  = maddr;
        miss_valid = 1'b1;
        req_valid  = aging;
        line_miss  = aging ? 4'b0001 : 4'b0000;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (rst_after > 0 && beats_total >= rst_after) begin
                rst = 1'b1;
                miss_valid = 1'b0;
                mem_out_valid = 1'b0;
                mem_wr_ack = 1'b0;
                @(negedge clk);
                #1;
                check_zero({nm, "_rst"});
                rst = 1'b0;
                return;
            end
            flush_data = prev_rd ? fdat(prev_addr) : 32'hDEAD_BEEF;
            mem_wr_ack = mem_wrreq && (held >= ack_dly);
            if (pend > 0) begin
                mem_out_valid = 1'b1;
                mem_out = gdat(baddr);
                baddr += 32'd4;
                pend--;
                beats_total++;
                last_beat = cyc;
            end else begin
                mem_out_valid = 1'b0;
                mem_out = '0;
            end
            #1;
            if (mode_seen == 4'd0) mode_seen = flush_mode;
            prev_rd = flush_rd;
            if (flush_rd) begin
                prev_addr = flush_addr;
                chk({nm, "_rd_addr"}, flush_addr, exp_sect + 32'(4 * nwr));
            end
            if (mem_wrreq) begin
                if (held == 0) begin
                    wa = mem_addr;
                    wd = mem_in;
                    chk({nm, "_wr_addr"}, mem_addr, exp_sect + 32'(4 * nwr));
                    chk({nm, "_wr_data"}, mem_in, fdat(exp_sect + 32'(4 * nwr)));
                end else begin
                    chk({nm, "_wr_hold"}, {mem_addr, mem_in}, {wa, wd});
                end
                if (mem_wr_ack) begin
                    nwr++;
                    held = 0;
                end else held++;
            end
            if (mem_rdreq) begin
                chk({nm, "_rdreq_addr"}, mem_addr, base + 32'(4 * nfill));
                chk({nm, "_rd_after_wb"}, 128'(nwr), exp_dirty ? 128'd32 : 128'd0);
                nrd++;
                pend = b;
                baddr = mem_addr;
            end
            if (flush_we) begin
                chk({nm, "_fill_addr"}, flush_addr, base + 32'(4 * nfill));
                chk({nm, "_fill_data"}, flush_in, gdat(base + 32'(4 * nfill)));
                nfill++;
            end
            if (miss_ack) begin
                done = 1;
                ack_cyc = cyc;
                busy_at_ack = busy;
                mode_at_ack = flush_mode;
            end
            cyc++;
        end
        chk({nm, "_ack_seen"}, 128'(done), 128'd1);
        chk({nm, "_ack_timing"}, 128'(ack_cyc), 128'(last_beat + 1));
        chk({nm, "_busy_at_ack"}, 128'(busy_at_ack), 128'd1);
        chk({nm, "_mode_at_ack"}, 128'(mode_at_ack), 128'd0);
        chk({nm, "_victim"}, 128'(mode_seen), 128'(exp_mode));
        chk({nm, "_rdreqs"}, 128'(nrd), 128'((32 + b - 1) / b));
        chk({nm, "_fills"}, 128'(nfill), 128'd32);
        chk({nm, "_writebacks"}, 128'(nwr), exp_dirty ? 128'd32 : 128'd0);
        @(negedge clk);
        miss_valid = 1'b0;
        req_valid = 1'b0;
        line_miss = '0;
        mem_out_valid = 1'b0;
        mem_wr_ack = 1'b0;
        #1;
        chk({nm, "_idle_busy"}, 128'(busy), 128'd0);
        chk({nm, "_idle_ack"}, 128'(miss_ack), 128'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero("post_reset");
        // line0 hits, lines 1..3 saturate at 255; tie resolves to line1
        age(300, 4'b1110);
        run_miss("clean_b8", 32'h0001_2345, 16'd8, 0, 0, 0, 4'b0010, 0, 32'h0);
        // line2 (TTL 255, dirty, section 0x1000) with slow write acks and single-beat bursts;
        // req_valid stays high while busy and must not age anything
        run_miss("dirty_b0", 32'h0000_2000, 16'd0, 5, 1, 0, 4'b0100, 1, 32'h1000);
        run_miss("clean_b48", 32'h0000_4000, 16'd48, 0, 0, 0, 4'b1000, 0, 32'h0);
        run_miss("rst_fill", 32'h8000_0000, 16'd8, 0, 0, 5, 4'b0001, 0, 32'h0);
        run_miss("restart", 32'h8000_0040, 16'd8, 0, 0, 0, 4'b0001, 0, 32'h0);
        // line3 saturates at 255 then loses 100; line2 gains 100 -> line3 still oldest
        age(300, 4'b1000);
        age(100, 4'b0100);
        run_miss("sat_b16", 32'h0000_FFFC, 16'd16, 0, 0, 0, 4'b1000, 0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_evict_ctrl.md
Name: dcache_evict_ctrl

Overview:
- Parametrised replacement/refill sequencer for the data cache. It ages LINENUM cache lines with saturating TTL counters and picks the oldest line as the victim when all lines miss.
- A dirty victim is written back word by word before refill. The refill uses bursts of memory-declared length, with line size set by CACHEADDRBITS rather than a fixed alignment.
- It sits between the line array and the memory controller and replaces the fixed 4-line controller state machine.

Parameters:
DATABITS, 32, data word width
ADDRBITS, 32, byte address width
CACHEADDRBITS, 5, log2 of words per line (WORDS=2**CACHEADDRBITS)
LINENUM, 4, number of cache lines (>=2)
TTLBITS, 8, TTL counter width
MAXTTL, 255, TTL saturation value (<=2**TTLBITS-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core rd/wr access this cycle
line_miss  in  LINENUM  per-line miss flag for the current access
line_dirty  in  LINENUM  per-line dirty flag
line_memory_section  in  LINENUM*ADDRBITS  line-aligned base address of each line; line i at bits [i*ADDRBITS +: ADDRBITS]
miss_valid  in  1  refill request; held until miss_ack
miss_addr  in  ADDRBITS  missing byte address
miss_ack  out  1  one-cycle pulse when refill is complete
busy  out  1  high in every state except IDLE
flush_mode  out  LINENUM  one-hot victim select during flush/fill, else 0
flush_rd  out  1  read line word at flush_addr; data arrives next cycle
flush_data  in  DATABITS  line read data
flush_we  out  1  write flush_in into victim at flush_addr
flush_addr  out  ADDRBITS  byte address of the line word
flush_in  out  DATABITS  fill data to the line
mem_addr  out  ADDRBITS  memory byte address
mem_in  out  DATABITS  write data
mem_wrreq  out  1  held until mem_wr_ack
mem_wr_ack  in  1  write word accepted
mem_rdreq  out  1  one-cycle burst-start pulse
mem_out  in  DATABITS  read data
mem_out_valid  in  1  read beat valid
mem_burstlen  in  16  beats per read burst; 0 is treated as 1

Behaviour:
- Reset: all outputs 0, all TTLs 0, state IDLE.
- States: IDLE, SELECT, FLUSH_RD, FLUSH_WR, FILL_REQ, FILL_DATA, DONE.
- Aging (IDLE only): when req_valid=1 and line_miss is not all ones:
  - a missing line's TTL increments, saturating at MAXTTL;
  - a hitting line's TTL decrements, saturating at 0.
  - No aging occurs in any other state.
- IDLE -> SELECT: on miss_valid.
- SELECT (1 cycle):
  - Victim = highest TTL; ties go to the lowest index. Victim TTL is set to 0.
  - flush_mode is set to the victim's one-hot and held through FILL_DATA.
  - Word counter cnt=0.
  - Next state is FLUSH_RD if the victim is dirty, else FILL_REQ.
- FLUSH_RD:
  - flush_rd=1 for one cycle, flush_addr = section + 4*cnt. Then FLUSH_WR.
- FLUSH_WR:
  - First cycle: capture flush_data into mem_in; mem_addr = flush_addr; mem_wrreq=1.
  - Hold until mem_wr_ack, then drop mem_wrreq and cnt++.
  - If cnt reaches WORDS: cnt=0 and go to FILL_REQ; else go to FLUSH_RD.
- FILL_REQ:
  - base = miss_addr with the low CACHEADDRBITS+2 bits cleared.
  - mem_addr = base + 4*cnt; mem_rdreq=1 for one cycle.
  - Latch the beat count B = max(mem_burstlen, 1). Then FILL_DATA.
- FILL_DATA: on each mem_out_valid:
  - if cnt < WORDS: flush_we=1, flush_addr = base + 4*cnt, flush_in = mem_out, cnt++;
  - beats beyond WORDS are consumed with flush_we=0.
  - After B beats: go to DONE if cnt == WORDS, else to FILL_REQ.
- DONE: miss_ack=1 for one cycle, flush_mode=0, then IDLE.
- Ignored inputs:
  - mem_out_valid outside FILL_DATA;
  - mem_wr_ack outside FLUSH_WR;
  - miss_valid while busy.
- Arithmetic: counters are CACHEADDRBITS+1 bits; address arithmetic wraps modulo 2**ADDRBITS.
- Reset mid-operation: return to IDLE at once, all strobes drop, no miss_ack. The victim line contents are undefined.

Test Plan:
- Aging: 300 accesses where line0 hits and the others miss -> ttl0=0, ttl1..3=255 (saturated); the next miss_valid selects line1 (tie broken to lowest index).
- Clean refill, WORDS=32, burstlen=8:
  - exactly 4 mem_rdreq pulses at base, +32, +64, +96;
  - 32 flush_we writes;
  - miss_ack one cycle after the 32nd beat.
- Dirty victim, section=0x1000: 32 writes at 0x1000..0x107C with data equal to the prior cycle's flush_data, each held until mem_wr_ack; then the fill proceeds.
- mem_wr_ack delayed 5 cycles -> mem_wrreq, mem_addr and mem_in stay stable for all 5 cycles.
- Edge cases:
  - burstlen=0 -> 32 single-beat bursts;
  - burstlen=48 -> one burst, beats 33..48 are not written;
  - miss_addr=0x12345 -> base 0x12300.
- Reset asserted in FILL_DATA -> next cycle all outputs 0 and busy=0; a new miss_valid restarts a clean refill.
